lab03_scan_sequencer: RTL
=========================

# lab03_scan_sequencer

Registered scan sequencer that drives the 3-bit select lines (A2..A0) of the 3-to-8 decoder stage directly downstream. It steps through the eight decoder channels in ascending order, skipping channels disabled by a mask. Each enabled channel is held for a programmable dwell time. Two modes are supported: continuous scan and one-shot sweep, with start/stop control and status pulses.

## Interface
- DWELL_W, 8, width of the per-channel dwell count
- clk  input  1  rising-edge clock, only clock in the block
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk
- start  input  1  request to begin scanning; single-cycle pulse
- stop  input  1  request to abort scanning; single-cycle pulse
- mode  input  1  0 = continuous scan, 1 = one-shot sweep
- mask  input  8  channel enable, bit i enables channel i
- dwell  input  DWELL_W  cycles each channel is held; 0 is treated as 1
- step  input  1  single-step request; present only with SCAN_STEP_EN
- A2, A1, A0  output  1 each  channel select to the decoder (A2 is the MSB)
- valid  output  1  select is meaningful; gates the decoder outputs
- busy  output  1  high in every state except IDLE
- wrap  output  1  one-cycle pulse on wrap-around to a lower or equal channel
- done  output  1  one-cycle pulse when a one-shot sweep or step completes

## Operation
- States: IDLE, SCAN, FINISH. SCAN_STEP_EN adds STEP.
- Reset (reset_n=0 at a clk edge): state=IDLE, {A2,A1,A0}=0, valid=0, busy=0, wrap=0, done=0, dwell counter=0.
  - Reset takes priority over every other input, including during SCAN.
- IDLE, start=1, stop=0, mask≠0:
  - load the lowest enabled channel into sel
  - load cnt = max(dwell,1)-1
  - valid=1, go to SCAN
- IDLE, start=1 with mask=0: ignored; stay in IDLE.
- SCAN:
  - cnt decrements every cycle.
  - When cnt=0, advance to the next enabled channel strictly above sel, modulo 8. Sample mask and dwell at this point, then reload cnt.
  - If the next channel is ≤ the current sel (wrap):
    - mode=0: keep scanning and pulse wrap.
    - mode=1: go to FINISH instead of loading the channel.
  - With a single enabled channel, every advance counts as a wrap.
  - mask=0 at an advance: abort to IDLE, valid=0, no done.
- stop=1 in SCAN or STEP: go to IDLE next cycle, valid=0, no done.
- Simultaneous start and stop: stop wins.
- start during SCAN is ignored.
- FINISH: lasts one cycle; valid=0, done=1; then IDLE.
- In IDLE, sel holds its last value and valid=0.
- mode is sampled only at a wrap decision.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- start sampled at edge N → valid=1 with the first channel visible after edge N, for cycle N+1.
- Each channel is held for exactly D=max(dwell,1) consecutive cycles.
  - The channel change is visible on the cycle after the one where cnt=0.
- wrap is high during the first cycle of the re-entered channel.
- One-shot sweep with k enabled channels and dwell D:
  - valid is high for k·D cycles.
  - done is high in the following cycle, with valid=0.
  - busy is low one cycle after done.
- stop sampled at edge M → valid=0 and busy=0 from cycle M+1.
- dwell changes during a dwell period take effect only at the next channel load.

## Configuration
- SCAN_STEP_EN defined: the step port and the STEP state exist.
  - IDLE, step=1, mask≠0: load the next enabled channel strictly above the current sel (modulo 8) and hold it valid for D cycles.
  - Then FINISH (done pulse) and back to IDLE.
  - start has priority over step when both are asserted.
  - wrap pulses if the step wrapped.
- SCAN_STEP_EN undefined: no step port and no STEP state. All other behaviour is identical.

## Test plan
- Reset mid-SCAN:
  - Stimulus: mask=FF, dwell=3, mode=0, start; assert reset_n=0 at cycle 5.
  - Required: next cycle sel=0, valid=busy=wrap=done=0, state IDLE.
- One-shot sweep:
  - Stimulus: mask=8'b1010_0101, dwell=2, mode=1, start.
  - Required: sel sequence 0,0,2,2,5,5,7,7 with valid=1, then done=1 for one cycle, then busy=0; wrap never asserts.
- Continuous wrap:
  - Stimulus: mask=8'b1000_0010, dwell=0, mode=0.
  - Required: sel alternates 1,7,1,7; each change to channel 1 after the first carries wrap=1; dwell=0 holds each channel for 1 cycle.
- Control conflicts:
  - start with mask=0 → no response.
  - start and stop in the same cycle in IDLE → stays in IDLE.
  - stop at cycle 4 of a scan → valid=0 from cycle 5, no done.
- Mask removed mid-scan:
  - Stimulus: mask=FF, dwell=4; set mask=0 during channel 2.
  - Required: at the advance, abort to IDLE, valid=0, no done.
- With SCAN_STEP_EN:
  - Stimulus: in IDLE with sel=7, mask=8'b0000_1001, dwell=3, pulse step.
  - Required: sel=0, valid=1 for 3 cycles with wrap=1 in the first, then done, then IDLE.

Source files
------------

// File: rtl/lab03_scan_sequencer_if.sv
// rtl/lab03_scan_sequencer_if.sv - control and decoder-select bundle for the scan sequencer
// SCAN_STEP_EN adds the step request line.
interface lab03_scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
`ifdef SCAN_STEP_EN
  logic               step;
`endif
  logic               A2;
  logic               A1;
  logic               A0;
  logic               valid;
  logic               busy;
  logic               wrap;
  logic               done;

  modport master (
    output start, stop, mode, mask, dwell,
`ifdef SCAN_STEP_EN
    output step,
`endif
    input  A2, A1, A0, valid, busy, wrap, done
  );

  modport slave (
    input  start, stop, mode, mask, dwell,
`ifdef SCAN_STEP_EN
    input  step,
`endif
    output A2, A1, A0, valid, busy, wrap, done
  );
endinterface

// File: rtl/lab03_scan_sequencer.sv
// rtl/lab03_scan_sequencer.sv - masked 3-to-8 decoder scan sequencer with dwell, one-shot and continuous modes
// SCAN_STEP_EN adds the single-step request and the STEP state.
module lab03_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  lab03_scan_sequencer_if.slave bus
);

`ifdef SCAN_STEP_EN
  typedef enum logic [1:0] {IDLE, SCAN, FINISH, STEP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;
`endif

  state_t             state, state_n;
  logic [2:0]         sel, sel_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic               wrap_q, wrap_n;
  logic [DWELL_W-1:0] reload;
  logic [2:0]         nxt;
  logic               nxt_wraps;
  logic               mask_any;

  // First enabled channel strictly above cur, modulo 8; cur itself if it is the only one.
  function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [7:0] m);
    logic [2:0] c;
    next_ch = cur;
    for (int i = 8; i >= 1; i--) begin
      c = cur + 3'(i);
      if (m[c]) next_ch = c;
    end
  endfunction

  assign reload    = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
  assign nxt       = next_ch(sel, bus.mask);
  assign nxt_wraps = (nxt <= sel);
  assign mask_any  = (bus.mask != 8'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      sel    <= 3'd0;
      cnt    <= '0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_n;
      sel    <= sel_n;
      cnt    <= cnt_n;
      wrap_q <= wrap_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    wrap_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop && mask_any) begin
          state_n = SCAN;
          sel_n   = next_ch(3'd7, bus.mask);
          cnt_n   = reload;
        end
`ifdef SCAN_STEP_EN
        else if (bus.step && !bus.stop && !bus.start && mask_any) begin
          state_n = STEP;
          sel_n   = nxt;
          cnt_n   = reload;
          wrap_n  = nxt_wraps;
        end
`endif
      end
      SCAN: begin
        if (bus.stop) begin
          state_n = IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - DWELL_W'(1);
        end else if (!mask_any) begin
          state_n = IDLE;
        end else if (nxt_wraps && bus.mode) begin
          state_n = FINISH;
        end else begin
          sel_n  = nxt;
          cnt_n  = reload;
          wrap_n = nxt_wraps;
        end
      end
`ifdef SCAN_STEP_EN
      STEP: begin
        if (bus.stop) begin
          state_n = IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - DWELL_W'(1);
        end else begin
          state_n = FINISH;
        end
      end
`endif
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign {bus.A2, bus.A1, bus.A0} = sel;
`ifdef SCAN_STEP_EN
  assign bus.valid = (state == SCAN) || (state == STEP);
`else
  assign bus.valid = (state == SCAN);
`endif
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == FINISH);
  assign bus.wrap = wrap_q;

endmodule
